pi1_wrbuf: RTL
==============

# pi1_wrbuf

Posted-write buffer for the pi1 interconnect, inserted between a pi1r slave port and `pi1_dcache` on the SDRAM path. Writes are absorbed into a small FIFO and acknowledged in the cycle they are presented, so the CPU does not wait on the dcache and SDRAM. The buffer drains to the dcache in order. Reads and read-writes wait until the FIFO is empty and then pass straight through, so downstream ordering is always preserved.

## Interface
Parameters:
- `ARCHBITSZ`, 32: data width; address width is `ARCHBITSZ-clog2(ARCHBITSZ/8)`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports (`AW` = address width, `SW` = `ARCHBITSZ/8`):
- `clk_i`  in  1  single clock domain; everything is sampled on its rising edge.
- `rst_i`  in  1  reset; asynchronous assert, active-low.
- `m_pi1_op_i`  in  2  upstream op: 00 NOOP, 01 WR, 10 RD, 11 RW.
- `m_pi1_addr_i`  in  AW  upstream word address.
- `m_pi1_data_i`  in  ARCHBITSZ  upstream write data.
- `m_pi1_data_o`  out  ARCHBITSZ  upstream read data.
- `m_pi1_sel_i`  in  SW  upstream byte select.
- `m_pi1_rdy_o`  out  1  upstream ready.
- `s_pi1_op_o`  out  2  downstream op.
- `s_pi1_addr_o`  out  AW  downstream address.
- `s_pi1_data_o`  out  ARCHBITSZ  downstream write data.
- `s_pi1_data_i`  in  ARCHBITSZ  downstream read data.
- `s_pi1_sel_o`  out  SW  downstream byte select.
- `s_pi1_rdy_i`  in  1  downstream ready.
- `empty_o`  out  1  FIFO empty; used as a fence/status indication.

## Operation
- **pi1 transfer rule.** A transfer completes in a cycle where op ≠ NOOP and rdy = 1. For RD and RW, read data is valid on data in that same cycle.
- **FIFO contents.** Each entry holds {addr, data, sel}. The FIFO uses write pointer `wp`, read pointer `rp`, and occupancy `cnt` (width `clog2(DEPTH)+1`). Pointers wrap modulo `DEPTH`.
- **Write acceptance.** When `m_pi1_op_i`=WR, `m_pi1_rdy_o` = (`cnt` != `DEPTH`). This uses the registered `cnt`, so a pop in the same cycle does not free a slot early. On acceptance, the entry is pushed at `wp`.
- **Drain path (`cnt` != 0).**
  - `s_pi1_op_o`=WR; addr, data and sel come from the entry at `rp`.
  - When `s_pi1_rdy_i`=1, the entry is popped.
- **Read / RW hold (`cnt` != 0).** When the upstream op is RD or RW, `m_pi1_rdy_o`=0 and the request does not go downstream.
- **Read / RW passthrough (`cnt` = 0).** When the upstream op is RD or RW:
  - `s_pi1_op_o`/addr/data/sel = upstream values.
  - `m_pi1_rdy_o` = `s_pi1_rdy_i`.
- **Idle downstream.** When `cnt`=0 and the upstream op is NOOP or WR, `s_pi1_op_o`=NOOP. A newly pushed write appears downstream the next cycle.
- **Read data.** `m_pi1_data_o` = `s_pi1_data_i` at all times.
- **Simultaneous push and pop.** `cnt` is unchanged and both pointers advance.
- **Upstream NOOP.** `m_pi1_rdy_o`=1 whenever not in reset.
- **State summary.**
  - EMPTY (`cnt`=0): passthrough allowed.
  - DRAIN (0<`cnt`<`DEPTH`): reads are held; writes are accepted.
  - FULL (`cnt`=`DEPTH`): reads and writes are both held; draining continues.
  - Transitions follow `cnt` only.

## Timing
- **During reset (`rst_i`=0).**
  - `wp`, `rp` and `cnt` are cleared to 0.
  - `m_pi1_rdy_o`=0, `s_pi1_op_o`=NOOP, `empty_o`=1.
  - Addr, data and sel outputs are forced to 0.
- **Reset in the middle of operation.** All buffered writes are discarded. Any passthrough in flight is aborted because op is forced to NOOP.
- **Write latency.** A write accepted at cycle N is presented downstream at N+1 at the earliest, if the FIFO was empty.
- **Throughput.** Both ends sustain one write per cycle when `s_pi1_rdy_i` is held at 1.
- **Read-after-write.** If the last pending write pops at cycle K, the held read is forwarded at cycle K+1.
- **Passthrough read latency.** Zero added cycles; the path is combinational.
- **`empty_o`.** Registered: it equals (`cnt`==0).

## Test plan
- **Reset.** Hold `rst_i`=0 with upstream op=WR. Expect `m_pi1_rdy_o`=0, `s_pi1_op_o`=00, `empty_o`=1. Release reset and expect `m_pi1_rdy_o`=1 the same cycle.
- **Ordered drain.** Back-to-back writes to addr 0x10..0x13 with data 0xA0..0xA3, `s_pi1_rdy_i`=1. Expect downstream WRs in the same order starting one cycle later, 4 consecutive cycles, `empty_o`=1 afterwards.
- **Full.** Hold `s_pi1_rdy_i`=0 and issue 5 writes. The first 4 are accepted and the 5th sees `m_pi1_rdy_o`=0. Raise `s_pi1_rdy_i` for one cycle: one entry pops, and the 5th write is accepted the following cycle.
- **Read fence.** Write 0xDEADBEEF to 0x40, then immediately issue RD 0x40 with `s_pi1_rdy_i` delayed 3 cycles. Expect `m_pi1_rdy_o`=0 and no downstream RD until the write pops. The RD is forwarded next cycle; upstream data equals `s_pi1_data_i`.
- **Passthrough.** With the FIFO empty, issue RW to 0x80 with `s_pi1_rdy_i`=1. Expect `s_pi1_op_o`=11 in the same cycle, `m_pi1_rdy_o`=1, and `m_pi1_data_o`=`s_pi1_data_i`.
- **Reset mid-drain.** With 3 entries queued, pulse `rst_i` low. Expect `cnt`=0 and no further downstream writes after release.

Source files
------------

// File: rtl/pi1_wrbuf.sv
// pi1_wrbuf: posted-write buffer between a pi1r slave port and pi1_dcache.
// Upstream writes are absorbed into a small FIFO and acknowledged in the
// same cycle they are presented. The FIFO drains downstream in order.
// Reads and read-writes are held while the FIFO holds data, then pass
// straight through combinationally once it is empty, so downstream
// ordering is never violated.
module pi1_wrbuf #(
  parameter int ARCHBITSZ = 32,
  parameter int DEPTH     = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [1:0]                                  m_pi1_op_i,
  input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]    m_pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]                        m_pi1_data_i,
  output logic [ARCHBITSZ-1:0]                        m_pi1_data_o,
  input  logic [(ARCHBITSZ/8)-1:0]                    m_pi1_sel_i,
  output logic                                        m_pi1_rdy_o,
  output logic [1:0]                                  s_pi1_op_o,
  output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]    s_pi1_addr_o,
  output logic [ARCHBITSZ-1:0]                        s_pi1_data_o,
  input  logic [ARCHBITSZ-1:0]                        s_pi1_data_i,
  output logic [(ARCHBITSZ/8)-1:0]                    s_pi1_sel_o,
  input  logic                                        s_pi1_rdy_i,
  output logic                                        empty_o
);

  localparam int SW = ARCHBITSZ / 8;
  localparam int AW = ARCHBITSZ - $clog2(SW);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  localparam logic [1:0] OP_NOOP = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_RW   = 2'b11;

  // Occupancy class of the FIFO; it is a pure function of cnt.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_DRAIN = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  // FIFO storage: one {addr, data, sel} entry per slot.
  logic [AW-1:0]        addr_mem_q [DEPTH];
  logic [ARCHBITSZ-1:0] data_mem_q [DEPTH];
  logic [SW-1:0]        sel_mem_q  [DEPTH];

  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  state_e        state_q;
  state_e        state_d;
  logic          empty_q;

  logic          push_s;
  logic          pop_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;

  // Decode of the registered occupancy class.
  assign fifo_empty_s = (state_q == ST_EMPTY);
  assign fifo_full_s  = (state_q == ST_FULL);

  // Read data is a pure wire from the downstream port.
  assign m_pi1_data_o = s_pi1_data_i;
  assign empty_o      = empty_q;

  // Handshake and downstream mux: drain head entry, or pass a read through when empty.
  always_comb begin
    m_pi1_rdy_o  = 1'b0;
    s_pi1_op_o   = OP_NOOP;
    s_pi1_addr_o = '0;
    s_pi1_data_o = '0;
    s_pi1_sel_o  = '0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    if (!rst_i) begin
      // Reset holds every handshake and address/data output low.
      m_pi1_rdy_o = 1'b0;
    end else begin
      case (m_pi1_op_i)
        OP_NOOP: begin
          m_pi1_rdy_o = 1'b1;
        end
        OP_WR: begin
          // Registered fullness only: a same-cycle pop does not free a slot.
          m_pi1_rdy_o = !fifo_full_s;
          push_s      = !fifo_full_s;
        end
        OP_RD, OP_RW: begin
          if (fifo_empty_s) begin
            m_pi1_rdy_o  = s_pi1_rdy_i;
            s_pi1_op_o   = m_pi1_op_i;
            s_pi1_addr_o = m_pi1_addr_i;
            s_pi1_data_o = m_pi1_data_i;
            s_pi1_sel_o  = m_pi1_sel_i;
          end else begin
            m_pi1_rdy_o = 1'b0;
          end
        end
        default: begin
          m_pi1_rdy_o = 1'b0;
        end
      endcase
      if (!fifo_empty_s) begin
        s_pi1_op_o   = OP_WR;
        s_pi1_addr_o = addr_mem_q[rp_q];
        s_pi1_data_o = data_mem_q[rp_q];
        s_pi1_sel_o  = sel_mem_q[rp_q];
        pop_s        = s_pi1_rdy_i;
      end else begin
        pop_s = 1'b0;
      end
    end
  end

  // Next occupancy from the push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Occupancy class for the next cycle, derived only from the next count.
  always_comb begin
    state_d = ST_DRAIN;
    if (cnt_d == CNT_ZERO) begin
      state_d = ST_EMPTY;
    end else if (cnt_d == CNT_FULL) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_DRAIN;
    end
  end

  // Pointer, count, state and empty flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= CNT_ZERO;
      state_q <= ST_EMPTY;
      empty_q <= 1'b1;
    end else begin
      if (push_s) begin
        wp_q <= wp_q + PTR_ONE;
      end
      if (pop_s) begin
        rp_q <= rp_q + PTR_ONE;
      end
      cnt_q   <= cnt_d;
      state_q <= state_d;
      empty_q <= (cnt_d == CNT_ZERO);
    end
  end

  // Entry storage; cleared on reset so no stale data survives a discard.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
        sel_mem_q[i]  <= '0;
      end
    end else if (push_s) begin
      addr_mem_q[wp_q] <= m_pi1_addr_i;
      data_mem_q[wp_q] <= m_pi1_data_i;
      sel_mem_q[wp_q]  <= m_pi1_sel_i;
    end
  end

endmodule
